// File: rtl/pipelined_add_sub.sv
// Carry-sliced add/subtract: STAGES registers from operands to sum/cout/ovf.
// A single advance enable (out_ready || !out_valid) moves or freezes the whole pipeline.
module pipelined_add_sub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Per-stage registers: skewed operands, partial sum, slice carry, valid
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] v_q;
  logic              ovf_q;

  logic [WIDTH-1:0]  st_a [STAGES];
  logic [WIDTH-1:0]  st_b [STAGES];
  logic [WIDTH-1:0]  st_s [STAGES];
  logic [STAGES-1:0] st_c;
  logic [WIDTH-1:0]  nx_s [STAGES];
  logic [STAGES-1:0] nx_c;
  logic              nx_ovf;
  logic              en;

  assign out_valid = v_q[LAST];
  assign en        = out_ready || !out_valid;
  assign in_ready  = en;
  assign sum       = s_q[LAST];
  assign cout      = c_q[LAST];
  assign ovf       = ovf_q;

  // Stage 0 works straight off the ports; B is inverted once here for subtract.
  always_comb begin
    st_a[0] = a;
    st_b[0] = sub ? ~b : b;
    st_c[0] = cin;
    st_s[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      st_a[k] = a_q[k-1];
      st_b[k] = b_q[k-1];
      st_c[k] = c_q[k-1];
      st_s[k] = s_q[k-1];
    end
  end

  always_comb begin
    logic [SW:0] t;
    t = '0;
    for (int k = 0; k < STAGES; k++) begin
      t = {1'b0, st_a[k][k*SW +: SW]} + {1'b0, st_b[k][k*SW +: SW]} + {{SW{1'b0}}, st_c[k]};
      nx_s[k]              = st_s[k];
      nx_s[k][k*SW +: SW]  = t[SW-1:0];
      nx_c[k]              = t[SW];
    end
    // Carry into the MSB is recovered as a ^ b' ^ sum at that bit.
    nx_ovf = st_a[LAST][WIDTH-1] ^ st_b[LAST][WIDTH-1] ^ nx_s[LAST][WIDTH-1] ^ nx_c[LAST];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      c_q   <= '0;
      v_q   <= '0;
      ovf_q <= 1'b0;
    end else if (en) begin
      v_q[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        v_q[k] <= v_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= st_a[k];
        b_q[k] <= st_b[k];
        s_q[k] <= nx_s[k];
      end
      c_q   <= nx_c;
      ovf_q <= nx_ovf;
    end
  end

endmodule

// File: doc/pipelined_add_sub.md
PIPELINED_ADD_SUB -- requirements
Module: pipelined_add_sub

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits.
REQ-002 Parameter STAGES, default 4, number of pipeline stages and carry slices; WIDTH SHALL be an integer multiple of STAGES.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 in_valid  input  1  operand set on a/b/cin/sub is valid.
REQ-006 in_ready  output  1  block accepts an operand set this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in (in subtract mode: 1 = no borrow).
REQ-010 sub  input  1  0 = add, 1 = subtract.
REQ-011 out_valid  output  1  result on sum/cout/ovf is valid.
REQ-012 out_ready  input  1  downstream accepts the result this cycle.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry out of MSB.
REQ-015 ovf  output  1  two's-complement signed overflow.

Function
REQ-016 Arithmetic: B' = sub ? ~b : b; {cout, sum} = a + B' + cin, computed modulo 2^(WIDTH+1).
REQ-017 ovf = carry into MSB XOR carry out of MSB, for the same operation.
REQ-018 Slicing: slice k (k = 0..STAGES-1) covers bits [(k+1)*WIDTH/STAGES-1 : k*WIDTH/STAGES]; stage k adds slice k using the carry registered by stage k-1 (stage 0 uses cin).
REQ-019 Operand skew: the upper slices of a and B' are registered forward alongside the pipeline until their stage is reached; completed lower sum slices are carried forward to the output register.
REQ-020 Handshake: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
REQ-021 Global advance enable: en = out_ready || !out_valid; in_ready = en (combinational, no dependency on in_valid).
REQ-022 When en = 1, all stage registers and per-stage valid bits shift one stage; stage 0 valid loads in_valid.
REQ-023 When en = 0, all stage registers, valid bits and outputs SHALL hold their values.
REQ-024 Latency: with en held 1, a transfer accepted at edge N SHALL present out_valid with its result after edge N+STAGES-1, i.e. STAGES registers from input to output, with no combinational a/b-to-sum path.
REQ-025 Throughput: one operation per cycle while out_ready = 1; bubbles (in_valid = 0) propagate as invalid slots and are not collapsed.
REQ-026 Capacity: at most STAGES operations in flight; results leave in acceptance order; none lost or duplicated under any out_ready pattern.
REQ-027 sum/cout/ovf are don't-care when out_valid = 0, but SHALL remain stable while out_valid = 1 and out_ready = 0.
REQ-028 STAGES = 1 SHALL degenerate to a single registered full-width adder with identical handshake.

Reset
REQ-029 rst = 1 SHALL immediately clear all valid bits, all data registers, sum, cout and ovf to 0, with out_valid = 0.
REQ-030 While rst = 1, in_ready = 1 and no transfer is recorded; in-flight operations at reset are discarded.
REQ-031 The first edge after rst deasserts behaves as a normal cycle; an input presented on it is accepted.

Verification (WIDTH=16, STAGES=4)
REQ-032 a=0xFFFF, b=0x0001, cin=0, sub=0 -> after 4 edges: sum=0x0000, cout=1, ovf=0.
REQ-033 a=0x7FFF, b=0x0001, cin=0, sub=0 -> sum=0x8000, cout=0, ovf=1; a=0x8000, b=0xFFFF, sub=0, cin=0 -> sum=0x7FFF, cout=1, ovf=1.
REQ-034 a=0x0005, b=0x0007, sub=1, cin=1 -> sum=0xFFFE, cout=0, ovf=0; a=0x0007, b=0x0005, sub=1, cin=1 -> sum=0x0002, cout=1.
REQ-035 Continuous in_valid with out_ready=0 for 10 cycles -> exactly 4 accepts, then in_ready=0 and outputs stable; after out_ready=1, all results emerge in order with no loss.
REQ-036 200 back-to-back random operations with random sub/cin and out_ready=1 -> one result per cycle, all matching the REQ-016/017 model.
REQ-037 Assert rst for 1 cycle with 3 operations in flight -> out_valid=0 immediately; none of the 3 results ever appear; the next accepted operation emerges after 4 edges.
